// File: rtl/sr_latch_bank_pkg.sv
// ============================================================================
// Module   : sr_latch_bank_pkg
// Brief    : Shared collision-priority encodings and counter sizing helper
//            for the registered SR latch bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_latch_bank_pkg;

    localparam int PRIO_RESET = 0;
    localparam int PRIO_SET   = 1;
    localparam int PRIO_HOLD  = 2;

    // Min-on counter width; a zero lock still needs one bit to exist.
    function automatic int cnt_width(input int min_on);
        int w;
        w = $clog2(min_on + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_latch_chan.sv
// ============================================================================
// Module   : sr_latch_chan
// Brief    : One registered SR channel with collision priority, min-on lock,
//            deferred reset and sticky collision flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_chan
    import sr_latch_bank_pkg::*;
#(
    parameter int PRIORITY = 0,
    parameter int MIN_ON   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    input  logic clr_err,
    output logic q,
    output logic locked,
    output logic pend,
    output logic err
);

    localparam int                  c_cnt_w  = cnt_width(MIN_ON);
    localparam logic [c_cnt_w-1:0]  c_min_on = c_cnt_w'(MIN_ON);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

    logic               r_q;
    logic               r_pend;
    logic               r_err;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_coll;
    logic w_es;
    logic w_er;
    logic w_cnt_zero;

    assign w_coll     = s & r;
    assign w_cnt_zero = (r_cnt == '0);

    // Resolve a simultaneous set/reset into at most one effective request.
    always_comb begin
        w_es = s & ~r;
        w_er = r & ~s;
        case (PRIORITY)
            PRIO_RESET: w_er = r;
            PRIO_SET:   w_es = s;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= 1'b0;
            r_pend <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_coll) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end

            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_cnt_one;
            end

            if (!r_q) begin
                if (w_es) begin
                    r_q    <= 1'b1;
                    r_cnt  <= c_min_on;
                    r_pend <= 1'b0;
                end
            end else if (w_es) begin
                // A fresh set cancels a deferred reset but never retriggers the lock.
                r_pend <= 1'b0;
            end else if (w_er) begin
                if (w_cnt_zero) begin
                    r_q    <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    r_pend <= 1'b1;
                end
            end else if (r_pend && w_cnt_zero) begin
                r_q    <= 1'b0;
                r_pend <= 1'b0;
            end
        end
    end

    assign q      = r_q;
    assign pend   = r_pend;
    assign err    = r_err;
    assign locked = r_q & ~w_cnt_zero;

endmodule

`default_nettype wire

// File: rtl/sr_latch_bank.sv
// ============================================================================
// Module   : sr_latch_bank
// Brief    : WIDTH independent registered SR channels with min-on lock.
//            Define SR_LATCH_BANK_EDGE_EN to add rise/fall pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_bank
    import sr_latch_bank_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRIORITY = PRIO_RESET,
    parameter int MIN_ON   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] locked,
    output logic [WIDTH-1:0] pend,
    output logic [WIDTH-1:0] err
`ifdef SR_LATCH_BANK_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        sr_latch_chan #(
            .PRIORITY (PRIORITY),
            .MIN_ON   (MIN_ON)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .s       (s[gi]),
            .r       (r[gi]),
            .clr_err (clr_err),
            .q       (q[gi]),
            .locked  (locked[gi]),
            .pend    (pend[gi]),
            .err     (err[gi])
        );
    end

`ifdef SR_LATCH_BANK_EDGE_EN
    logic [WIDTH-1:0] r_q_d;

    // Reset clears q and its copy together, so reset never produces a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_d <= '0;
        end else begin
            r_q_d <= q;
        end
    end

    assign rise = q & ~r_q_d;
    assign fall = ~q & r_q_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank.sv
// ============================================================================
// Module   : tb_sr_latch_bank
// Brief    : Six bank instances (PRIORITY 0..2 x MIN_ON 0/3) driven in
//            parallel and compared against a cycle-age reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_bank;

    localparam int W  = 4;
    localparam int NI = 6;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] s       = '0;
    logic [W-1:0] r       = '0;

    logic [W-1:0] q_a      [NI];
    logic [W-1:0] locked_a [NI];
    logic [W-1:0] pend_a   [NI];
    logic [W-1:0] err_a    [NI];
`ifdef SR_LATCH_BANK_EDGE_EN
    logic [W-1:0] rise_a   [NI];
    logic [W-1:0] fall_a   [NI];
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sr_latch_bank #(
            .WIDTH    (W),
            .PRIORITY (gi % 3),
            .MIN_ON   ((gi / 3) * 3)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .s       (s),
            .r       (r),
            .clr_err (clr_err),
            .q       (q_a[gi]),
            .locked  (locked_a[gi]),
            .pend    (pend_a[gi]),
            .err     (err_a[gi])
`ifdef SR_LATCH_BANK_EDGE_EN
            ,
            .rise    (rise_a[gi]),
            .fall    (fall_a[gi])
`endif
        );
    end

    // Reference model: channel on/off, edges elapsed since it rose, deferral flag.
    bit m_on   [NI][W];
    int m_age  [NI][W];
    bit m_pend [NI][W];
    bit m_err  [NI][W];
    bit m_prev [NI][W];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int prio_of(input int k);
        return k % 3;
    endfunction

    function automatic int minon_of(input int k);
        return (k / 3) * 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < W; i++) begin
                m_on[k][i]   = 1'b0;
                m_age[k][i]  = 0;
                m_pend[k][i] = 1'b0;
                m_err[k][i]  = 1'b0;
                m_prev[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < W; i++) begin
                bit si, ri, es, er, lock;
                si = s[i];
                ri = r[i];
                es = si && (!ri || prio_of(k) == 1);
                er = ri && (!si || prio_of(k) == 0);
                m_prev[k][i] = m_on[k][i];
                if (si && ri) m_err[k][i] = 1'b1;
                else if (clr_err) m_err[k][i] = 1'b0;
                if (!m_on[k][i]) begin
                    if (es) begin
                        m_on[k][i]   = 1'b1;
                        m_age[k][i]  = 0;
                        m_pend[k][i] = 1'b0;
                    end
                end else begin
                    lock = m_age[k][i] < minon_of(k);
                    if (es) begin
                        m_pend[k][i] = 1'b0;
                    end else if (er) begin
                        if (!lock) begin
                            m_on[k][i]   = 1'b0;
                            m_pend[k][i] = 1'b0;
                        end else begin
                            m_pend[k][i] = 1'b1;
                        end
                    end else if (m_pend[k][i] && !lock) begin
                        m_on[k][i]   = 1'b0;
                        m_pend[k][i] = 1'b0;
                    end
                    if (m_on[k][i]) m_age[k][i] = m_age[k][i] + 1;
                end
            end
        end
    endtask

    // kind: 0 q, 1 locked, 2 pend, 3 err, 4 rise, 5 fall
    function automatic logic [W-1:0] exp_vec(input int k, input int kind);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            case (kind)
                0:       v[i] = m_on[k][i];
                1:       v[i] = m_on[k][i] && (m_age[k][i] < minon_of(k));
                2:       v[i] = m_pend[k][i];
                3:       v[i] = m_err[k][i];
                4:       v[i] = m_on[k][i] && !m_prev[k][i];
                default: v[i] = !m_on[k][i] && m_prev[k][i];
            endcase
        end
        return v;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s/i%0d/q", tag, k),      32'(q_a[k]),      32'(exp_vec(k, 0)));
            chk($sformatf("%s/i%0d/locked", tag, k), 32'(locked_a[k]), 32'(exp_vec(k, 1)));
            chk($sformatf("%s/i%0d/pend", tag, k),   32'(pend_a[k]),   32'(exp_vec(k, 2)));
            chk($sformatf("%s/i%0d/err", tag, k),    32'(err_a[k]),    32'(exp_vec(k, 3)));
`ifdef SR_LATCH_BANK_EDGE_EN
            chk($sformatf("%s/i%0d/rise", tag, k),   32'(rise_a[k]),   32'(exp_vec(k, 4)));
            chk($sformatf("%s/i%0d/fall", tag, k),   32'(fall_a[k]),   32'(exp_vec(k, 5)));
`endif
        end
    endtask

    task automatic tick(input logic [W-1:0] sv, input logic [W-1:0] rv, input logic ce, input string tag);
        s       = sv;
        r       = rv;
        clr_err = ce;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Called at posedge+1; asserts and releases reset well between edges.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit tt_q [5];
        tt_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        model_reset();

        // Reset and idle
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) tick('0, '0, 1'b0, "idle");

        // Truth table on ch0
        tick(4'b0000, 4'b0001, 1'b0, "tt");
        chk("tt_q0_e0", 32'(q_a[0][0]), 32'(tt_q[0]));
        tick(4'b0001, 4'b0000, 1'b0, "tt");
        chk("tt_q0_e1", 32'(q_a[0][0]), 32'(tt_q[1]));
        tick(4'b0001, 4'b0001, 1'b0, "tt");
        chk("tt_q0_e2", 32'(q_a[0][0]), 32'(tt_q[2]));
        chk("tt_err0_set", 32'(err_a[0][0]), 32'd1);
        tick(4'b0001, 4'b0000, 1'b0, "tt");
        chk("tt_q0_e3", 32'(q_a[0][0]), 32'(tt_q[3]));
        tick(4'b0000, 4'b0000, 1'b0, "tt");
        chk("tt_q0_e4", 32'(q_a[0][0]), 32'(tt_q[4]));
        tick(4'b0000, 4'b0000, 1'b1, "tt");
        chk("tt_err0_clr", 32'(err_a[0][0]), 32'd0);

        // Priority sweep on the MIN_ON=0 instances
        tick(4'b0000, 4'b1111, 1'b1, "prio");
        tick(4'b1010, 4'b0000, 1'b1, "prio");
        chk("prio_pre_q", 32'(q_a[0]), 32'h0000000a);
        tick(4'b1111, 4'b1111, 1'b0, "prio");
        chk("prio0_q", 32'(q_a[0]), 32'h00000000);
        chk("prio1_q", 32'(q_a[1]), 32'h0000000f);
        chk("prio2_q", 32'(q_a[2]), 32'h0000000a);
        chk("prio0_err", 32'(err_a[0]), 32'h0000000f);
        chk("prio1_err", 32'(err_a[1]), 32'h0000000f);
        chk("prio2_err", 32'(err_a[2]), 32'h0000000f);

        // Min-on lock on instance 3 (reset-dominant, MIN_ON=3)
        async_reset("rst1");
        tick(4'b0010, 4'b0000, 1'b0, "lock");
        chk("lock_k_locked", 32'(locked_a[3][1]), 32'd1);
        tick(4'b0000, 4'b0010, 1'b0, "lock");
        chk("lock_k1_pend", 32'(pend_a[3][1]), 32'd1);
        chk("lock_k1_locked", 32'(locked_a[3][1]), 32'd1);
        tick('0, '0, 1'b0, "lock");
        chk("lock_k2_locked", 32'(locked_a[3][1]), 32'd1);
        tick('0, '0, 1'b0, "lock");
        chk("lock_k3_locked", 32'(locked_a[3][1]), 32'd0);
        chk("lock_k3_q", 32'(q_a[3][1]), 32'd1);
        tick('0, '0, 1'b0, "lock");
        chk("lock_k4_q", 32'(q_a[3][1]), 32'd0);
        chk("lock_k4_pend", 32'(pend_a[3][1]), 32'd0);

        // Set cancels a deferred reset
        tick(4'b0010, 4'b0000, 1'b0, "cancel");
        tick(4'b0000, 4'b0010, 1'b0, "cancel");
        chk("cancel_k1_pend", 32'(pend_a[3][1]), 32'd1);
        tick(4'b0010, 4'b0000, 1'b0, "cancel");
        chk("cancel_k2_pend", 32'(pend_a[3][1]), 32'd0);
        for (int c = 0; c < 4; c++) tick('0, '0, 1'b0, "cancel");
        chk("cancel_k6_q", 32'(q_a[3][1]), 32'd1);

        // Async reset mid-lock
        tick(4'b0000, 4'b0010, 1'b0, "midlock");
        tick(4'b0010, 4'b0000, 1'b0, "midlock");
        tick(4'b0000, 4'b0010, 1'b0, "midlock");
        chk("midlock_pend_pre", 32'(pend_a[3][1]), 32'd1);
        async_reset("midlock_rst");
        chk("midlock_q", 32'(q_a[3]), 32'd0);
        chk("midlock_pend", 32'(pend_a[3]), 32'd0);
        chk("midlock_locked", 32'(locked_a[3]), 32'd0);

`ifdef SR_LATCH_BANK_EDGE_EN
        tick(4'b0100, 4'b0000, 1'b0, "edge");
        chk("edge_rise_on", 32'(rise_a[0]), 32'h00000004);
        tick('0, '0, 1'b0, "edge");
        chk("edge_rise_off", 32'(rise_a[0]), 32'h00000000);
        tick(4'b0000, 4'b0100, 1'b0, "edge");
        chk("edge_fall_on", 32'(fall_a[0]), 32'h00000004);
        tick('0, '0, 1'b0, "edge");
        chk("edge_fall_off", 32'(fall_a[0]), 32'h00000000);
`endif

        // Randomized traffic across all instances
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] sv, rv;
            sv = W'($urandom_range(0, 15)) & W'($urandom_range(0, 15));
            rv = W'($urandom_range(0, 15)) & W'($urandom_range(0, 15));
            tick(sv, rv, ($urandom_range(0, 7) == 0), "rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Parametrised, clocked successor of the single SR latch.
- Holds WIDTH independent set/reset channels in registered form, with selectable collision priority and a per-channel minimum-on lock; pending resets are deferred until the lock expires.
- Sticky collision flags per channel.
- Used in the magnetron control path, where a channel must not be dropped before its minimum on-time has elapsed.

Parameters:
- WIDTH, 4, number of independent SR channels (1..16)
- PRIORITY, 0, behaviour when S and R are both high: 0 reset-dominant, 1 set-dominant, 2 hold
- MIN_ON, 0, minimum extra cycles a channel stays set after rising (0 = no lock; max 255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s  in  WIDTH  per-channel set request, sampled each clk
- r  in  WIDTH  per-channel reset request, sampled each clk
- clr_err  in  1  synchronous clear of all err bits
- q  out  WIDTH  registered channel state
- locked  out  WIDTH  channel is set and its min-on counter is nonzero
- pend  out  WIDTH  a reset is deferred, waiting for lock expiry
- err  out  WIDTH  sticky: S and R were seen high together on this channel

Behaviour:
- Reset: rst_n low clears all state at once, without waiting for clk: q, locked, pend, err, counters = 0. An assertion mid-lock discards the lock and any pending reset.
- Latency: requests sampled at edge k take effect in the register state after edge k.
- Request resolution per channel when s=r=1:
  - PRIORITY 0: effective reset
  - PRIORITY 1: effective set
  - PRIORITY 2: neither
  - In all three cases err[i] is set the same edge.
- err update: clr_err clears all err bits. If clr_err coincides with a new collision, the collision wins and err stays 1.
- Counter cnt[i], width clog2(MIN_ON+1), minimum 1 bit:
  - Loads MIN_ON on the edge where q[i] goes 0 to 1.
  - Decrements by 1 on each later edge while nonzero; saturates at 0.
- locked[i] = q[i] AND cnt[i] != 0 (combinational from registers).
- Per-channel transitions at each edge, given effective set (es) and effective reset (er):
  - q=0, es: q becomes 1, cnt loads MIN_ON, pend is cleared.
  - q=0, er or idle: no change.
  - q=1, er, cnt=0: q becomes 0, pend is cleared.
  - q=1, er, cnt!=0: pend becomes 1, q stays 1.
  - q=1, es: pend is cleared (set cancels a deferred reset); cnt is not retriggered.
  - q=1, idle, pend=1, cnt=0: q becomes 0, pend is cleared.
- Consequence: q stays high for at least MIN_ON+1 cycles.
- MIN_ON=0: locked and pend are always 0; the block degenerates to a registered SR bank.
- Channels are fully independent; a collision on one channel does not affect the others.

Optional Feature:
- Macro: SR_LATCH_BANK_EDGE_EN
- Defined:
  - Adds outputs rise (WIDTH) and fall (WIDTH).
  - Each is a one-cycle pulse in the cycle after q[i] goes 0 to 1, or 1 to 0.
  - Driven from a registered copy of q.
  - Both are 0 out of reset and are not pulsed by the reset itself.
- Not defined: ports and the q-copy register are absent; all other behaviour is identical.

Decomposition:
- Shared package: PRIORITY encodings (PRIO_RESET=0, PRIO_SET=1, PRIO_HOLD=2) and the counter-width helper function.
- One natural sub-module: sr_latch_chan, a single channel holding q, cnt, pend and err.
- sr_latch_bank instantiates sr_latch_chan WIDTH times in a generate loop.

Test Plan:
- Reset and idle: rst_n=0, then s=r=0 for 5 cycles -> q=0, locked=0, pend=0, err=0 throughout.
- Truth table: WIDTH=4, PRIORITY=0, MIN_ON=0; drive (s,r)=(0,1)(1,0)(1,1)(1,0)(0,0) on ch0, same pattern as the original latch bench.
  - q[0] after each edge: 0, 1, 0, 1, 1.
  - err[0]=1 from the (1,1) edge; clr_err=1 returns it to 0.
- Priority sweep: s=r=4'b1111 from q=4'b1010.
  - PRIORITY 0 -> q=0000.
  - PRIORITY 1 -> q=1111.
  - PRIORITY 2 -> q=1010.
  - err=1111 in all three cases.
- Min-on lock: MIN_ON=3; s[1] pulse at edge k, r[1] pulse at edge k+1.
  - pend[1]=1 after edge k+1.
  - locked[1] high after edges k..k+2.
  - q[1] falls after edge k+4; pend returns to 0.
- Cancel and async reset:
  - MIN_ON=3; set, then reset (pend=1), then set again at k+2 -> pend=0 and q[1] stays 1 past k+5.
  - Then rst_n=0 mid-lock -> q, pend, locked = 0 before the next edge.
- Edge option: SR_LATCH_BANK_EDGE_EN defined; set then reset on ch2 -> rise[2] one-cycle pulse, then fall[2] one-cycle pulse; no pulses on ch0, ch1, ch3.
